// File: rtl/shift_add_multiplier_pkg.sv
// Shared widths and FSM encodings for the shift-add multiplier (divider reconstruct unit).
package shift_add_multiplier_pkg;
    localparam int DEF_MCAND_W = 7;
    localparam int DEF_MPLR_W  = 8;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;
endpackage

// File: rtl/shift_add_multiplier_addsub.sv
// 1-bit add/subtract cell; as=1 inverts b so a chain with cin=1 subtracts.
module shift_add_multiplier_addsub (
    input  logic a,
    input  logic b,
    input  logic as,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic bx;

    assign bx   = b ^ as;
    assign s    = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: product = multiplicand*multiplier + addend, one bit per clock.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int MCAND_W = DEF_MCAND_W,
    parameter int MPLR_W  = DEF_MPLR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [MCAND_W-1:0]         multiplicand,
    input  logic [MPLR_W-1:0]          multiplier,
    input  logic [MCAND_W-1:0]         addend,
    output logic [MCAND_W+MPLR_W-1:0]  product,
    output logic                       busy,
    output logic                       done
);
    localparam int PROD_W = MCAND_W + MPLR_W;
    localparam int CNT_W  = (MPLR_W > 1) ? $clog2(MPLR_W) : 1;

    logic [1:0]         state;
    logic [MCAND_W-1:0] m_q;
    logic [MCAND_W-1:0] a_q;
    logic [MPLR_W-1:0]  q_q;
    logic [CNT_W-1:0]   cnt;
    logic [MCAND_W-1:0] sum;
    logic [MCAND_W:0]   carry;
    logic [PROD_W-1:0]  nxt_aq;

    // Ripple chain of addsub cells; B is gated by the current multiplier lsb.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < MCAND_W; i++) begin : g_cell
        shift_add_multiplier_addsub u_cell (
            .a    (a_q[i]),
            .b    (m_q[i] & q_q[0]),
            .as   (1'b0),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign nxt_aq = {carry[MCAND_W], sum, q_q[MPLR_W-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_q   <= multiplicand;
                        a_q   <= addend;
                        q_q   <= multiplier;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    {a_q, q_q} <= nxt_aq;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_W'(MPLR_W - 1)) begin
                        product <= nxt_aq;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: latency, results, abuse and mid-op reset.
module tb_shift_add_multiplier;
    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [6:0]  addend;
    logic [14:0] product;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int total    = 0;

    shift_add_multiplier dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_op(input logic [6:0] m, input logic [7:0] q, input logic [6:0] r,
                          output int cycles, output int busy_cycles, output logic [14:0] res);
        multiplicand = m; multiplier = q; addend = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0; busy_cycles = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            cycles++;
        end
        res = product;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        multiplicand = '0; multiplier = '0; addend = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({product, busy, done} !== 17'd0) $display("FAIL reset_hold: product=%0d busy=%0b done=%0b want 0/0/0", product, busy, done);
        else pass_cnt++;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({product, busy, done} !== 17'd0) $display("FAIL reset_idle: product=%0d busy=%0b done=%0b want 0/0/0", product, busy, done);
        else pass_cnt++;
    endtask

    task automatic test_basic(input logic [6:0] m, input logic [7:0] q, input logic [6:0] r,
                              input logic [14:0] exp, input string name);
        int cyc, bcyc;
        logic [14:0] res;
        run_op(m, q, r, cyc, bcyc, res);
        total++;
        if (cyc !== 8) $display("FAIL %s_latency: done after %0d cycles want 8", name, cyc);
        else pass_cnt++;
        total++;
        if (bcyc !== 8) $display("FAIL %s_busy: busy %0d cycles want 8", name, bcyc);
        else pass_cnt++;
        total++;
        if (res !== exp) $display("FAIL %s_product: got %0d want %0d", name, res, exp);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== exp)
            $display("FAIL %s_after: done=%0b busy=%0b product=%0d want 0/0/%0d", name, done, busy, product, exp);
        else pass_cnt++;
    endtask

    task automatic test_start_in_run();
        int cyc;
        multiplicand = 7'd13; multiplier = 8'd11; addend = 7'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        multiplicand = 7'd100; multiplier = 8'd99; addend = 7'd50; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (product !== 15'd0 && busy !== 1'b1)
            $display("FAIL rerun_busy: busy=%0b want 1", busy);
        else pass_cnt++;
        cyc = 3;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== 8) $display("FAIL rerun_latency: done after %0d cycles want 8", cyc);
        else pass_cnt++;
        total++;
        if (product !== 15'd145) $display("FAIL rerun_product: got %0d want 145", product);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) $display("FAIL rerun_no_queue: busy=%0b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        multiplicand = 7'd13; multiplier = 8'd11; addend = 7'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        total++;
        if ({product, busy, done} !== 17'd0)
            $display("FAIL midrst: product=%0d busy=%0b done=%0b want 0/0/0", product, busy, done);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) $display("FAIL midrst_idle: busy=%0b want 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic(7'd13,  8'd11,  7'd0,   15'd143,   "basic");
        test_basic(7'd127, 8'd255, 7'd126, 15'h7EFF,  "max");
        test_basic(7'd7,   8'd28,  7'd4,   15'd200,   "roundtrip");
        test_basic(7'd0,   8'd200, 7'd5,   15'd5,     "zero_m");
        test_basic(7'd9,   8'd0,   7'd0,   15'd0,     "zero_q");
        test_start_in_run();
        test_reset_mid_run();
        test_basic(7'd6,   8'd6,   7'd1,   15'd37,    "post_reset");
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
